// File: rtl/proc_pipe.sv
// proc_pipe: packet-processing sequencer.
//
// On an accepted start it runs the parser once, then walks the enabled
// matcher/executor stage pairs in ascending index order. Each stage hands its
// executor either the stage's hit or miss action address, depending on the
// matcher verdict. Every wait state (PARSE, MATCH, EXEC) is guarded by a
// watchdog that aborts the run when the expected ready does not arrive.
//
// Ports:
//   clk, rst            - clock (rising edge); asynchronous active-low reset
//   start_i             - request a run (accepted only when idle, no cfg write)
//   busy_o              - high while a run is in progress
//   done_o / err_o      - one-cycle completion pulse / abort qualifier
//   err_code_o          - 0 none, 1 parser, 2 matcher, 3 executor
//   err_stage_o         - stage index of the abort (0 for the parser)
//   hit_mask_o          - per-stage match result of the current/last run
//   cfg_*               - stage enable and hit/miss address write port, acked
//   ps_start_o/ps_ready_i                 - parser handshake
//   mt_start_o/mt_ready_i/mt_is_match_i   - per-stage matcher handshakes
//   ex_start_o/ex_ready_i                 - per-stage executor handshakes
//   ex_op_start_cnt_o   - action address, valid from the ex_start_o pulse
module proc_pipe #(
    parameter int NUM_STAGES = 4,
    parameter int ADDR_W     = 32,
    parameter int TIMEOUT    = 1024,
    parameter int STAGE_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [1:0]            err_code_o,
    output logic [STAGE_W-1:0]    err_stage_o,
    output logic [NUM_STAGES-1:0] hit_mask_o,
    input  logic                  cfg_we_i,
    input  logic [STAGE_W-1:0]    cfg_stage_i,
    input  logic                  cfg_en_i,
    input  logic [ADDR_W-1:0]     cfg_hit_addr_i,
    input  logic [ADDR_W-1:0]     cfg_miss_addr_i,
    output logic                  cfg_ack_o,
    output logic                  ps_start_o,
    input  logic                  ps_ready_i,
    output logic [NUM_STAGES-1:0] mt_start_o,
    input  logic [NUM_STAGES-1:0] mt_ready_i,
    input  logic [NUM_STAGES-1:0] mt_is_match_i,
    output logic [NUM_STAGES-1:0] ex_start_o,
    input  logic [NUM_STAGES-1:0] ex_ready_i,
    output logic [ADDR_W-1:0]     ex_op_start_cnt_o
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit WD_EN = (TIMEOUT > 0);
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        PARSE = 2'd1,
        MATCH = 2'd2,
        EXEC  = 2'd3
    } state_e;

    localparam logic [1:0] ERR_PARSER   = 2'd1;
    localparam logic [1:0] ERR_MATCHER  = 2'd2;
    localparam logic [1:0] ERR_EXECUTOR = 2'd3;

    state_e                state_q, state_d;
    logic [STAGE_W-1:0]    cur_q, cur_d;
    logic [WD_W-1:0]       wd_q, wd_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [1:0]            err_code_q, err_code_d;
    logic [STAGE_W-1:0]    err_stage_q, err_stage_d;
    logic [NUM_STAGES-1:0] hit_mask_q, hit_mask_d;
    logic                  cfg_ack_q, cfg_ack_d;
    logic                  ps_start_q, ps_start_d;
    logic [NUM_STAGES-1:0] mt_start_q, mt_start_d;
    logic [NUM_STAGES-1:0] ex_start_q, ex_start_d;
    logic [ADDR_W-1:0]     ex_addr_q, ex_addr_d;

    // Stage configuration table
    logic [NUM_STAGES-1:0] en_q;
    logic [ADDR_W-1:0]     hit_addr_q  [NUM_STAGES];
    logic [ADDR_W-1:0]     miss_addr_q [NUM_STAGES];
    logic                  cfg_wr;

    // Lowest enabled stage overall, and lowest enabled stage above cur_q.
    // Both are combinational so skipping disabled stages costs no cycles.
    logic                  first_vld, next_vld;
    logic [STAGE_W-1:0]    first_idx, next_idx;
    logic                  wd_expired;

    always_comb begin
        first_vld = 1'b0;
        first_idx = '0;
        next_vld  = 1'b0;
        next_idx  = '0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            if (en_q[i] && !first_vld) begin
                first_vld = 1'b1;
                first_idx = STAGE_W'(i);
            end
            if (en_q[i] && !next_vld && (i > 32'(cur_q))) begin
                next_vld = 1'b1;
                next_idx = STAGE_W'(i);
            end
        end
    end

    assign wd_expired = WD_EN && (wd_q == WD_LAST);

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        wd_d        = wd_q + WD_W'(1);
        done_d      = 1'b0;
        err_d       = err_q;
        err_code_d  = err_code_q;
        err_stage_d = err_stage_q;
        hit_mask_d  = hit_mask_q;
        cfg_ack_d   = 1'b0;
        ps_start_d  = 1'b0;
        mt_start_d  = '0;
        ex_start_d  = '0;
        ex_addr_d   = ex_addr_q;
        cfg_wr      = 1'b0;

        unique case (state_q)
            FREE: begin
                wd_d = '0;
                // A config write takes priority; a simultaneous start is dropped.
                if (cfg_we_i) begin
                    if (32'(cfg_stage_i) < NUM_STAGES) begin
                        cfg_wr    = 1'b1;
                        cfg_ack_d = 1'b1;
                    end
                end else if (start_i) begin
                    hit_mask_d  = '0;
                    err_d       = 1'b0;
                    err_code_d  = '0;
                    err_stage_d = '0;
                    cur_d       = '0;
                    ps_start_d  = 1'b1;
                    state_d     = PARSE;
                end
            end

            PARSE: begin
                if (ps_ready_i) begin
                    wd_d = '0;
                    if (first_vld) begin
                        cur_d                 = first_idx;
                        mt_start_d[first_idx] = 1'b1;
                        state_d               = MATCH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = FREE;
                    end
                end else if (wd_expired) begin
                    done_d      = 1'b1;
                    err_d       = 1'b1;
                    err_code_d  = ERR_PARSER;
                    err_stage_d = '0;
                    state_d     = FREE;
                end
            end

            MATCH: begin
                if (mt_ready_i[cur_q]) begin
                    wd_d              = '0;
                    hit_mask_d[cur_q] = mt_is_match_i[cur_q];
                    ex_addr_d         = mt_is_match_i[cur_q] ? hit_addr_q[cur_q]
                                                             : miss_addr_q[cur_q];
                    ex_start_d[cur_q] = 1'b1;
                    state_d           = EXEC;
                end else if (wd_expired) begin
                    done_d      = 1'b1;
                    err_d       = 1'b1;
                    err_code_d  = ERR_MATCHER;
                    err_stage_d = cur_q;
                    state_d     = FREE;
                end
            end

            EXEC: begin
                if (ex_ready_i[cur_q]) begin
                    wd_d = '0;
                    if (next_vld) begin
                        cur_d                = next_idx;
                        mt_start_d[next_idx] = 1'b1;
                        state_d              = MATCH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = FREE;
                    end
                end else if (wd_expired) begin
                    done_d      = 1'b1;
                    err_d       = 1'b1;
                    err_code_d  = ERR_EXECUTOR;
                    err_stage_d = cur_q;
                    state_d     = FREE;
                end
            end

            default: state_d = FREE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FREE;
            cur_q       <= '0;
            wd_q        <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
            err_stage_q <= '0;
            hit_mask_q  <= '0;
            cfg_ack_q   <= 1'b0;
            ps_start_q  <= 1'b0;
            mt_start_q  <= '0;
            ex_start_q  <= '0;
            ex_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            wd_q        <= wd_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            err_stage_q <= err_stage_d;
            hit_mask_q  <= hit_mask_d;
            cfg_ack_q   <= cfg_ack_d;
            ps_start_q  <= ps_start_d;
            mt_start_q  <= mt_start_d;
            ex_start_q  <= ex_start_d;
            ex_addr_q   <= ex_addr_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q <= '1;
            for (int unsigned i = 0; i < NUM_STAGES; i++) begin
                hit_addr_q[i]  <= '0;
                miss_addr_q[i] <= '0;
            end
        end else if (cfg_wr) begin
            en_q[cfg_stage_i]        <= cfg_en_i;
            hit_addr_q[cfg_stage_i]  <= cfg_hit_addr_i;
            miss_addr_q[cfg_stage_i] <= cfg_miss_addr_i;
        end
    end

    assign busy_o            = (state_q != FREE);
    assign done_o            = done_q;
    assign err_o             = err_q;
    assign err_code_o        = err_code_q;
    assign err_stage_o       = err_stage_q;
    assign hit_mask_o        = hit_mask_q;
    assign cfg_ack_o         = cfg_ack_q;
    assign ps_start_o        = ps_start_q;
    assign mt_start_o        = mt_start_q;
    assign ex_start_o        = ex_start_q;
    assign ex_op_start_cnt_o = ex_addr_q;

endmodule

// File: tb/tb_proc_pipe.sv
// Bench for proc_pipe: a scoreboard of expected handshake/completion events
// (kind, cycle, payload) built from a reference walk of the stage table, and
// a responder that returns each ready one cycle after its start pulse.
module tb_proc_pipe;

    localparam int NS = 4;
    localparam int AW = 32;
    localparam int TO = 8;

    localparam int K_PS   = 0;
    localparam int K_MT   = 1;
    localparam int K_EX   = 2;
    localparam int K_DONE = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start_i = 1'b0;
    logic          busy_o, done_o, err_o;
    logic [1:0]    err_code_o;
    logic [1:0]    err_stage_o;
    logic [NS-1:0] hit_mask_o;
    logic          cfg_we_i = 1'b0;
    logic [1:0]    cfg_stage_i = '0;
    logic          cfg_en_i = 1'b0;
    logic [AW-1:0] cfg_hit_addr_i = '0;
    logic [AW-1:0] cfg_miss_addr_i = '0;
    logic          cfg_ack_o;
    logic          ps_start_o;
    logic          ps_ready_i = 1'b0;
    logic [NS-1:0] mt_start_o;
    logic [NS-1:0] mt_ready_i = '0;
    logic [NS-1:0] mt_is_match_i = '0;
    logic [NS-1:0] ex_start_o;
    logic [NS-1:0] ex_ready_i = '0;
    logic [AW-1:0] ex_op_start_cnt_o;

    proc_pipe #(
        .NUM_STAGES(NS),
        .ADDR_W    (AW),
        .TIMEOUT   (TO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .err_o            (err_o),
        .err_code_o       (err_code_o),
        .err_stage_o      (err_stage_o),
        .hit_mask_o       (hit_mask_o),
        .cfg_we_i         (cfg_we_i),
        .cfg_stage_i      (cfg_stage_i),
        .cfg_en_i         (cfg_en_i),
        .cfg_hit_addr_i   (cfg_hit_addr_i),
        .cfg_miss_addr_i  (cfg_miss_addr_i),
        .cfg_ack_o        (cfg_ack_o),
        .ps_start_o       (ps_start_o),
        .ps_ready_i       (ps_ready_i),
        .mt_start_o       (mt_start_o),
        .mt_ready_i       (mt_ready_i),
        .mt_is_match_i    (mt_is_match_i),
        .ex_start_o       (ex_start_o),
        .ex_ready_i       (ex_ready_i),
        .ex_op_start_cnt_o(ex_op_start_cnt_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference copy of the stage table
    logic          m_en   [NS];
    logic [AW-1:0] m_hit  [NS];
    logic [AW-1:0] m_miss [NS];

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_en[i]   = 1'b1;
            m_hit[i]  = '0;
            m_miss[i] = '0;
        end
    endtask

    typedef struct {
        int          kind;
        int          cyc;
        logic [63:0] data;
    } evt_t;

    evt_t exq[$];

    task automatic push_evt(input int k, input int c, input logic [63:0] d);
        evt_t e;
        e.kind = k;
        e.cyc  = c;
        e.data = d;
        exq.push_back(e);
    endtask

    function automatic logic [63:0] done_word(input logic e, input logic [1:0] code,
                                              input logic [1:0] st, input logic [3:0] m);
        return {54'd0, 1'b0, e, code, st, m};
    endfunction

    // Expected events for a run accepted in cycle t, with every ready coming
    // one cycle after its pulse unless the named unit hangs.
    // hang_kind: 0 none, 1 parser, 2 matcher, 3 executor.
    task automatic expect_run(input int t, input logic [3:0] match,
                              input int hang_kind, input int hang_stage);
        int         c;
        logic [3:0] mask;
        logic [3:0] onehot;
        c    = t + 1;
        mask = '0;
        push_evt(K_PS, c, 64'd0);
        if (hang_kind == 1) begin
            push_evt(K_DONE, c + TO, done_word(1'b1, 2'd1, 2'd0, mask));
            return;
        end
        c += 2;
        for (int s = 0; s < NS; s++) begin
            if (m_en[s]) begin
                onehot = 4'(1 << s);
                push_evt(K_MT, c, {60'd0, onehot});
                if (hang_kind == 2 && hang_stage == s) begin
                    push_evt(K_DONE, c + TO, done_word(1'b1, 2'd2, 2'(s), mask));
                    return;
                end
                mask[s] = match[s];
                c += 2;
                push_evt(K_EX, c, {28'd0, onehot, match[s] ? m_hit[s] : m_miss[s]});
                if (hang_kind == 3 && hang_stage == s) begin
                    push_evt(K_DONE, c + TO, done_word(1'b1, 2'd3, 2'(s), mask));
                    return;
                end
                c += 2;
            end
        end
        push_evt(K_DONE, c, done_word(1'b0, 2'd0, 2'd0, mask));
    endtask

    task automatic handle(input int k, input logic [63:0] d);
        evt_t e;
        check_eq("evt_pending", 64'(exq.size() != 0), 64'd1);
        if (exq.size() != 0) begin
            e = exq.pop_front();
            check_eq("evt_kind", 64'(k), 64'(e.kind));
            check_eq("evt_cycle", 64'(cyc), 64'(e.cyc));
            check_eq("evt_data", d, e.data);
        end
    endtask

    // Monitor: samples DUT outputs on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            if (ps_start_o)      handle(K_PS, 64'd0);
            if (mt_start_o != 0) handle(K_MT, {60'd0, mt_start_o});
            if (ex_start_o != 0) handle(K_EX, {28'd0, ex_start_o, ex_op_start_cnt_o});
            if (done_o)          handle(K_DONE, {54'd0, busy_o, err_o, err_code_o,
                                                 err_stage_o, hit_mask_o});
        end
    end

    // Responder: each ready follows its start pulse by one cycle
    logic          hang_ps = 1'b0;
    logic [NS-1:0] hang_mt = '0;
    logic [NS-1:0] hang_ex = '0;
    logic [NS-1:0] match_v = '0;
    logic          ps_pend = 1'b0;
    logic [NS-1:0] mt_pend = '0;
    logic [NS-1:0] ex_pend = '0;

    always @(negedge clk) begin
        if (!rst) begin
            ps_pend    = 1'b0;
            mt_pend    = '0;
            ex_pend    = '0;
            ps_ready_i = 1'b0;
            mt_ready_i = '0;
            ex_ready_i = '0;
        end else begin
            ps_ready_i    = ps_pend;
            mt_ready_i    = mt_pend;
            ex_ready_i    = ex_pend;
            mt_is_match_i = match_v;
            ps_pend       = ps_start_o & ~hang_ps;
            mt_pend       = mt_start_o & ~hang_mt;
            ex_pend       = ex_start_o & ~hang_ex;
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 100 && exq.size() != 0; i++) @(negedge clk);
        check_eq("drain", 64'(exq.size()), 64'd0);
        exq.delete();
        hang_ps = 1'b0;
        hang_mt = '0;
        hang_ex = '0;
    endtask

    task automatic launch(input logic [3:0] match, input int hang_kind, input int hang_stage);
        @(negedge clk);
        match_v = match;
        hang_ps = (hang_kind == 1);
        hang_mt = (hang_kind == 2) ? 4'(1 << hang_stage) : 4'd0;
        hang_ex = (hang_kind == 3) ? 4'(1 << hang_stage) : 4'd0;
        expect_run(cyc, match, hang_kind, hang_stage);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic run(input logic [3:0] match, input int hang_kind, input int hang_stage);
        launch(match, hang_kind, hang_stage);
        wait_drain();
    endtask

    task automatic cfg_write(input int st, input logic en, input logic [31:0] ha,
                             input logic [31:0] ma);
        @(negedge clk);
        cfg_we_i        = 1'b1;
        cfg_stage_i     = 2'(st);
        cfg_en_i        = en;
        cfg_hit_addr_i  = ha;
        cfg_miss_addr_i = ma;
        @(negedge clk);
        cfg_we_i = 1'b0;
        check_eq("cfg_ack", 64'(cfg_ack_o), 64'd1);
        m_en[st]   = en;
        m_hit[st]  = ha;
        m_miss[st] = ma;
    endtask

    function automatic logic [63:0] all_outs();
        return {11'd0, busy_o, done_o, err_o, err_code_o, err_stage_o, hit_mask_o,
                cfg_ack_o, ps_start_o, mt_start_o, ex_start_o, ex_op_start_cnt_o};
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_outs", all_outs(), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("idle_outs", all_outs(), 64'd0);

        // Defaults: all stages, stage 0 matches, addresses 0
        run(4'b0001, 0, 0);

        // Stage 2 addresses, stages 1 and 3 disabled; stage 2 misses then hits
        cfg_write(2, 1'b1, 32'h40, 32'h80);
        cfg_write(1, 1'b0, 32'h0, 32'h0);
        cfg_write(3, 1'b0, 32'h0, 32'h0);
        run(4'b0001, 0, 0);
        run(4'b0100, 0, 0);

        // No enabled stage: done at T+3, no matcher pulse
        cfg_write(0, 1'b0, 32'h0, 32'h0);
        cfg_write(2, 1'b0, 32'h40, 32'h80);
        run(4'b1111, 0, 0);

        // Re-enable everything, then watchdog aborts of each unit kind
        cfg_write(0, 1'b1, 32'h0, 32'h0);
        cfg_write(1, 1'b1, 32'h0, 32'h0);
        cfg_write(2, 1'b1, 32'h40, 32'h80);
        cfg_write(3, 1'b1, 32'h0, 32'h0);
        run(4'b0001, 3, 1);
        run(4'b0011, 2, 2);
        run(4'b0000, 1, 0);

        // Config write and start together: write wins, no run
        @(negedge clk);
        cfg_we_i        = 1'b1;
        start_i         = 1'b1;
        cfg_stage_i     = 2'd0;
        cfg_en_i        = 1'b1;
        cfg_hit_addr_i  = 32'h11;
        cfg_miss_addr_i = 32'h22;
        @(negedge clk);
        cfg_we_i = 1'b0;
        start_i  = 1'b0;
        check_eq("cfg_ack_start", 64'(cfg_ack_o), 64'd1);
        check_eq("dropped_start", {62'd0, ps_start_o, busy_o}, 64'd0);
        m_hit[0]  = 32'h11;
        m_miss[0] = 32'h22;

        // Config write and start while busy: both ignored
        launch(4'b0101, 0, 0);
        cfg_we_i        = 1'b1;
        start_i         = 1'b1;
        cfg_stage_i     = 2'd0;
        cfg_en_i        = 1'b0;
        cfg_hit_addr_i  = 32'hDEAD;
        cfg_miss_addr_i = 32'hBEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("busy_cfg_noack", 64'(cfg_ack_o), 64'd0);
        end
        cfg_we_i = 1'b0;
        start_i  = 1'b0;
        wait_drain();
        run(4'b1101, 0, 0);

        // Asynchronous reset during MATCH
        launch(4'b0001, 0, 0);
        for (int i = 0; i < 20 && mt_start_o == 0; i++) @(negedge clk);
        check_eq("reached_match", 64'(mt_start_o != 0), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("async_reset_outs", all_outs(), 64'd0);
        exq.delete();
        hang_ps = 1'b0;
        hang_mt = '0;
        hang_ex = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
        run(4'b1111, 0, 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
